result_streamer: RTL and testbench

- Drains the CPU result stack through its read side (`result`, `result_empty`, pop strobe) and serialises each 64-bit value as a framed byte stream on a valid/ready link.
- Also reports the CPU trap code as its own frame.
- Sits between the cpu core and the host-facing byte transport. It is the consumer end of the result interface the cpu exposes.

---
 rtl/result_streamer.sv | 175 +++++++++++++++++
 tb/tb_result_streamer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_streamer.sv
// result_streamer: drains the cpu result stack and sends each word as a framed
// byte stream on a valid/ready link. A non-zero trap code is sent as its own
// frame, after which the block halts until reset.
//
// Frame formats:
//   result : HDR_RESULT, then WIDTH/8 data bytes, least significant byte first
//   end    : HDR_END, sent when a drain session finds the stack empty
//   trap   : HDR_TRAP | trap, after which the block sits in HALT
//
// Ports:
//   clk, reset          clock and asynchronous active-low reset
//   start               pulse that begins a drain session (honoured in IDLE only)
//   result/result_empty top of the cpu result stack and its empty flag
//   trap                cpu trap code, 0 means no trap
//   result_pop          strobe that removes the top of the stack (LOAD only)
//   tx_data/tx_valid    registered byte stream output
//   tx_ready            sink ready; a byte moves when tx_valid & tx_ready
//   busy/halted         status: busy outside IDLE/HALT, halted in HALT
module result_streamer #(
    parameter int unsigned WIDTH      = 64,
    parameter logic [7:0]  HDR_RESULT = 8'h01,
    parameter logic [7:0]  HDR_END    = 8'h00,
    parameter logic [7:0]  HDR_TRAP   = 8'h80
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] result,
    input  logic             result_empty,
    input  logic [2:0]       trap,
    output logic             result_pop,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             halted
);

    localparam int unsigned NBYTES = WIDTH / 8;
    localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HDR,
        S_DATA,
        S_END,
        S_TRAP,
        S_HALT
    } state_t;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] shift_q, shift_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [7:0]       data_n;
    logic             valid_n;
    logic             busy_n;
    logic             halted_n;
    logic             handshake;
    logic             trap_hit;
    logic [WIDTH-1:0] shifted;

    assign handshake = tx_valid && tx_ready;
    assign trap_hit  = (trap != 3'd0);
    assign shifted   = shift_q >> 8;

    // Pop must see result_empty in the very cycle it fires, so it is decoded
    // from the registered LOAD state and the live stack/trap inputs.
    assign result_pop = (state_q == S_LOAD) && !trap_hit && !result_empty;

    // Next-state and next-output decode.
    always_comb begin
        state_n = state_q;
        shift_n = shift_q;
        cnt_n   = cnt_q;
        data_n  = tx_data;
        valid_n = tx_valid;

        case (state_q)
            S_IDLE: begin
                if (trap_hit) begin
                    state_n = S_TRAP;
                    data_n  = HDR_TRAP | {5'b0, trap};
                    valid_n = 1'b1;
                end else if (start) begin
                    state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                if (trap_hit) begin
                    state_n = S_TRAP;
                    data_n  = HDR_TRAP | {5'b0, trap};
                    valid_n = 1'b1;
                end else if (!result_empty) begin
                    state_n = S_HDR;
                    shift_n = result;
                    data_n  = HDR_RESULT;
                    valid_n = 1'b1;
                end else begin
                    state_n = S_END;
                    data_n  = HDR_END;
                    valid_n = 1'b1;
                end
            end
            S_HDR: begin
                if (handshake) begin
                    state_n = S_DATA;
                    cnt_n   = '0;
                    data_n  = shift_q[7:0];
                end
            end
            S_DATA: begin
                if (handshake) begin
                    shift_n = shifted;
                    if (cnt_q == LAST_BYTE) begin
                        // Frame complete; the next word is only popped now.
                        state_n = S_LOAD;
                        data_n  = 8'h00;
                        valid_n = 1'b0;
                    end else begin
                        cnt_n  = cnt_q + CNT_W'(1);
                        data_n = shifted[7:0];
                    end
                end
            end
            S_END: begin
                if (handshake) begin
                    state_n = S_IDLE;
                    data_n  = 8'h00;
                    valid_n = 1'b0;
                end
            end
            S_TRAP: begin
                if (handshake) begin
                    state_n = S_HALT;
                    data_n  = 8'h00;
                    valid_n = 1'b0;
                end
            end
            S_HALT: begin
                valid_n = 1'b0;
            end
            default: begin
                state_n = S_IDLE;
                valid_n = 1'b0;
            end
        endcase

        busy_n   = (state_n != S_IDLE) && (state_n != S_HALT);
        halted_n = (state_n == S_HALT);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state_q  <= state_n;
            shift_q  <= shift_n;
            cnt_q    <= cnt_n;
            tx_data  <= data_n;
            tx_valid <= valid_n;
            busy     <= busy_n;
            halted   <= halted_n;
        end
    end

endmodule

// File: tb/tb_result_streamer.sv
// Self-checking bench for result_streamer: a queue-based stack model feeds the
// DUT, accepted bytes are captured and compared with frames built from the
// framing rules.
module tb_result_streamer;

    localparam int unsigned WIDTH = 64;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] result;
    logic             result_empty;
    logic [2:0]       trap;
    logic             result_pop;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             busy;
    logic             halted;

    result_streamer #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .result       (result),
        .result_empty (result_empty),
        .trap         (trap),
        .result_pop   (result_pop),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] stack[$];
    logic [7:0]       got[$];
    logic [7:0]       exp_q[$];
    int               vectors;
    int               miscompares;
    int               pops;
    bit               pend_pop;
    bit               rdy_rand;
    bit               prev_stall;
    logic [7:0]       prev_data;
    logic             start_d;
    logic [2:0]       trap_d;
    logic             rst_d;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: update the stack model, drive inputs after the falling edge,
    // then observe what the next rising edge will act on.
    task automatic cycle();
        @(negedge clk);
        if (pend_pop && stack.size() > 0) void'(stack.pop_front());
        pend_pop = 1'b0;
        reset = rst_d;
        start = start_d;
        trap  = trap_d;
        if (stack.size() > 0) begin
            result       = stack[0];
            result_empty = 1'b0;
        end else begin
            result       = '0;
            result_empty = 1'b1;
        end
        tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (!reset) begin
            check("rst_valid", 64'(tx_valid), 64'd0);
            check("rst_pop", 64'(result_pop), 64'd0);
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(tx_valid), 64'd1);
                check("hold_data", 64'(tx_data), 64'(prev_data));
            end
            if (result_pop) begin
                pops++;
                pend_pop = 1'b1;
                check("pop_nonempty", 64'(result_empty), 64'd0);
            end
            if (tx_valid && tx_ready) got.push_back(tx_data);
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    endtask

    task automatic pulse_start();
        start_d = 1'b1;
        cycle();
        start_d = 1'b0;
    endtask

    task automatic do_reset();
        rst_d = 1'b0;
        repeat (3) cycle();
        rst_d = 1'b1;
        cycle();
        got.delete();
        pops     = 0;
        pend_pop = 1'b0;
    endtask

    // Keep clocking until n bytes have been accepted, then a few idle cycles
    // so that any surplus bytes would also be captured.
    task automatic run_bytes(input int n, input string tag);
        int c;
        c = 0;
        while (got.size() < n && c < 400) begin
            cycle();
            c++;
        end
        if (got.size() < n) check({tag, "_timeout"}, 64'(got.size()), 64'(n));
        repeat (6) cycle();
    endtask

    function automatic void add_frame(input logic [WIDTH-1:0] w);
        exp_q.push_back(8'h01);
        for (int i = 0; i < WIDTH / 8; i++) exp_q.push_back(w[8*i +: 8]);
    endfunction

    task automatic cmp_stream(input string tag);
        check({tag, "_len"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check(tag, 64'(got[i]), 64'(exp_q[i]));
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        int               c;
        vectors     = 0;
        miscompares = 0;
        pops        = 0;
        pend_pop    = 1'b0;
        rdy_rand    = 1'b0;
        prev_stall  = 1'b0;
        prev_data   = 8'h00;
        start_d     = 1'b0;
        trap_d      = 3'd0;
        rst_d       = 1'b0;
        reset       = 1'b0;
        start       = 1'b0;
        trap        = 3'd0;
        result      = '0;
        result_empty = 1'b1;
        tx_ready    = 1'b1;

        // Reset state
        do_reset();
        check("reset_valid", 64'(tx_valid), 64'd0);
        check("reset_data", 64'(tx_data), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_halted", 64'(halted), 64'd0);

        // Single result, no backpressure
        stack.push_back(64'h0123456789ABCDEF);
        add_frame(64'h0123456789ABCDEF);
        exp_q.push_back(8'h00);
        pulse_start();
        run_bytes(10, "single");
        cmp_stream("single");
        check("single_pops", 64'(pops), 64'd1);
        check("single_busy", 64'(busy), 64'd0);

        // Empty stack gives a lone terminator
        pops = 0;
        exp_q.push_back(8'h00);
        pulse_start();
        run_bytes(1, "empty");
        cmp_stream("empty");
        check("empty_pops", 64'(pops), 64'd0);
        check("empty_busy", 64'(busy), 64'd0);

        // Two results with random backpressure
        pops = 0;
        rdy_rand = 1'b1;
        stack.push_back(64'h1);
        stack.push_back(64'h2);
        add_frame(64'h1);
        add_frame(64'h2);
        exp_q.push_back(8'h00);
        pulse_start();
        run_bytes(19, "two");
        cmp_stream("two");
        check("two_pops", 64'(pops), 64'd2);

        // Random words, random backpressure
        for (int k = 0; k < 3; k++) begin
            pops = 0;
            w = {$urandom, $urandom};
            stack.push_back(w);
            add_frame(w);
            exp_q.push_back(8'h00);
            pulse_start();
            run_bytes(10, "rand");
            cmp_stream("rand");
            check("rand_pops", 64'(pops), 64'd1);
        end

        // Trap raised while data byte 2 is pending; frame finishes first
        pops = 0;
        w = {$urandom, $urandom};
        stack.push_back(w);
        stack.push_back(64'hDEAD);
        add_frame(w);
        exp_q.push_back(8'h83);
        pulse_start();
        c = 0;
        while (got.size() < 10 && c < 400) begin
            cycle();
            if (got.size() >= 3 && trap_d == 3'd0) trap_d = 3'd3;
            // Once the trap byte is on the wire the live code may change.
            if (tx_valid && tx_data == 8'h83) trap_d = 3'd6;
            c++;
        end
        if (got.size() < 10) check("trap_timeout", 64'(got.size()), 64'd10);
        repeat (6) cycle();
        cmp_stream("trap_frame");
        check("trap_halted", 64'(halted), 64'd1);
        check("trap_busy", 64'(busy), 64'd0);
        check("trap_pops", 64'(pops), 64'd1);
        pulse_start();
        repeat (20) cycle();
        check("halt_silent", 64'(got.size()), 64'd0);
        check("halt_pops", 64'(pops), 64'd1);
        check("halt_stays", 64'(halted), 64'd1);

        // Trap while idle
        trap_d = 3'd0;
        stack.delete();
        do_reset();
        stack.push_back(64'h55);
        trap_d = 3'd5;
        exp_q.push_back(8'h85);
        run_bytes(1, "trap_idle");
        cmp_stream("trap_idle");
        check("trap_idle_halted", 64'(halted), 64'd1);
        check("trap_idle_pops", 64'(pops), 64'd0);

        // Reset mid-frame, then a fresh frame
        trap_d = 3'd0;
        stack.delete();
        do_reset();
        rdy_rand = 1'b0;
        w = {$urandom, $urandom};
        stack.push_back(w);
        pulse_start();
        c = 0;
        while (got.size() < 5 && c < 100) begin
            cycle();
            c++;
        end
        check("midrst_reach", 64'(got.size()), 64'd5);
        rst_d = 1'b0;
        repeat (3) cycle();
        rst_d = 1'b1;
        stack.delete();
        pend_pop = 1'b0;
        cycle();
        got.delete();
        pops = 0;
        check("midrst_busy", 64'(busy), 64'd0);
        stack.push_back(64'hFF);
        add_frame(64'hFF);
        exp_q.push_back(8'h00);
        pulse_start();
        run_bytes(10, "midrst");
        cmp_stream("midrst");
        check("midrst_pops", 64'(pops), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
